// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mul_pkg;

    localparam int unsigned MUL_N     = 32;
    localparam int unsigned MUL_STEPS = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

endpackage

// File: rtl/mul_seq_if.sv
// Operand/result valid-ready bus of mul_seq; master is the sequencer, slave the multiplier.
interface mul_seq_if #(
    parameter int unsigned N = mul_pkg::MUL_N
) ();

    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] product;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product
    );

endinterface

// File: rtl/add_co.sv
// N-bit ripple-carry adder with carry-in and carry-out.
module add_co #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    logic [N:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < N; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[N];
    end

endmodule

// File: rtl/mul_seq.sv
// Sequential 32x32 unsigned shift-and-add multiplier, one multiplier bit per cycle.
// Define MUL_SEQ_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module mul_seq
    import mul_pkg::*;
(
    input logic       clk,
    input logic       rst,
    mul_seq_if.slave  bus
);

    localparam int unsigned N = MUL_N;

    state_e           state_q, state_d;
    logic [2*N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]     mplier_q, mplier_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [4:0]       count_q, count_d;

    logic [N-1:0]     sum_lo, sum_hi;
    logic             co_lo, co_hi;
    logic             exit_now;

    add_co #(.N(N)) u_add_lo (
        .a (acc_q[N-1:0]),
        .b (mcand_q[N-1:0]),
        .ci(1'b0),
        .s (sum_lo),
        .co(co_lo)
    );

    add_co #(.N(N)) u_add_hi (
        .a (acc_q[2*N-1:N]),
        .b (mcand_q[2*N-1:N]),
        .ci(co_lo),
        .s (sum_hi),
        .co(co_hi)
    );

`ifdef MUL_SEQ_EARLY_EXIT_EN
    assign exit_now = (mplier_q == '0);
`else
    assign exit_now = 1'b0;
`endif

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.product   = acc_q;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mcand_d  = {{N{1'b0}}, bus.a};
                    mplier_d = bus.b;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (exit_now) begin
                    state_d = DONE;
                end else begin
                    if (mplier_q[0]) acc_d = {sum_hi, sum_lo};
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + 5'd1;
                    if (count_q == 5'(MUL_STEPS - 1)) state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

    // acc < a*2^k and mcand = a*2^k, so the 2N-bit sum never carries out.
    always_ff @(posedge clk) begin
        if (!rst && state_q == BUSY && mplier_q[0]) assert (!co_hi);
    end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed test-plan cases plus random operands
// checked against an arithmetic reference model (product and latency).
module tb_mul_seq;
    import mul_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mul_seq_if bus ();

    mul_seq dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b);
        return 64'(a) * 64'(b);
    endfunction

    function automatic int ref_latency(input logic [31:0] b);
`ifdef MUL_SEQ_EARLY_EXIT_EN
        int m;
        m = -1;
        if (b == 32'd0) return 1;
        for (int i = 0; i < 32; i++) if (b[i]) m = i;
        return (m + 2 < 32) ? m + 2 : 32;
`else
        return (b === 32'hx) ? 0 : 32;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete operation; stall>0 holds out_ready low for that many DONE cycles.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input bit toggle_junk, input int stall);
        int cyc;
        logic [63:0] held;
        cyc = 0;
        while (!bus.in_ready && cyc < 200) begin
            tick;
            cyc++;
        end
        check({tag, " in_ready idle"}, 64'(bus.in_ready), 64'd1);
        bus.a         = a;
        bus.b         = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = (stall == 0);
        tick;
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        check({tag, " in_ready busy"}, 64'(bus.in_ready), 64'd0);
        cyc = 1;
        while (!bus.out_valid && cyc <= 100) begin
            if (toggle_junk) begin
                bus.in_valid = ~bus.in_valid;
                bus.a        = 32'd9;
                bus.b        = 32'd9;
            end
            tick;
            if (!bus.out_valid) cyc++;
        end
        bus.in_valid = 1'b0;
        check({tag, " latency"}, 64'(cyc), 64'(ref_latency(b)));
        check({tag, " product"}, bus.product, ref_product(a, b));
        held = bus.product;
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 32'd9;
            bus.b        = 32'd9;
            tick;
            check({tag, " stall out_valid"}, 64'(bus.out_valid), 64'd1);
            check({tag, " stall product"}, bus.product, held);
            check({tag, " stall in_ready"}, 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick;
        check({tag, " post out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, " post in_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_valid;
        logic [31:0] ra, rb;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (3) tick;
        check("reset in_ready", 64'(bus.in_ready), 64'd0);
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset product", bus.product, 64'd0);
        rst = 1'b0;
        #1;
        check("post-reset in_ready", 64'(bus.in_ready), 64'd1);

        run_op("3x5", 32'd3, 32'd5, 1'b0, 0);
        run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("carry", 32'h8000_0000, 32'd2, 1'b0, 0);
        run_op("backpressure", 32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 10);

        // Reset in the middle of an operation discards it.
        bus.a        = 32'd7;
        bus.b        = 32'd6;
        bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        repeat (10) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        check("midrst out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst product", bus.product, 64'd0);
        check("midrst in_ready", 64'(bus.in_ready), 64'd1);
        seen_valid = 1'b0;
        repeat (40) begin
            tick;
            if (bus.out_valid) seen_valid = 1'b1;
        end
        check("midrst no stale result", 64'(seen_valid), 64'd0);
        run_op("7x6 reissue", 32'd7, 32'd6, 1'b0, 0);

        run_op("2x3 junk", 32'd2, 32'd3, 1'b1, 0);
        repeat (3) tick;
        check("junk never accepted", 64'(bus.in_ready), 64'd1);

        run_op("b=0", 32'hCAFE_F00D, 32'd0, 1'b0, 0);
        run_op("5x1", 32'd5, 32'd1, 1'b0, 0);
        run_op("x10", 32'h1234_5678, 32'h10, 1'b0, 0);
        run_op("msb", 32'h0000_0003, 32'h8000_0000, 1'b0, 0);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_op($sformatf("rand%0d", i), ra, rb, 1'b0, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mul_seq.md
# mul_seq

Sequential 32×32 unsigned shift-and-add multiplier for the 32-bit datapath, placed directly downstream of the integer adder and built on it. One multiplier bit per cycle; a 64-bit add step is built from two chained 32-bit adders. Valid/ready handshake on both input and output, so the sequencer can stall the result.

## Interface
- `N`, 32: operand width; product is 2N bits.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  operands `a`, `b` present.
- `in_ready`  out  1  block can accept; high only in IDLE and `rst` low.
- `a`  in  N  multiplicand, sampled only on accept.
- `b`  in  N  multiplier, sampled only on accept.
- `out_valid`  out  1  `product` valid.
- `out_ready`  in  1  consumer takes `product`.
- `product`  out  2N  registered a×b, unsigned.

## Operation
- States: IDLE, BUSY, DONE.
- Registers: `mcand` (2N, left-shifting), `mplier` (N, right-shifting), `acc` (2N), `count` (5 bits).
- IDLE: accept on `in_valid && in_ready`: `mcand={0,a}`, `mplier=b`, `acc=0`, `count=0` → BUSY.
- BUSY step, one per cycle:
  - If `mplier[0]`, `acc = acc + mcand` (mod 2^2N, cannot overflow).
  - Then `mcand <<= 1`, `mplier >>= 1`, `count++`.
  - When `count==31`, the step is performed and the state goes → DONE.
- DONE: `out_valid=1`, `product=acc`. Both are held stable until `out_ready`; on the handshake → IDLE.
- `in_valid` outside IDLE is ignored. `in_ready` is 0 in BUSY/DONE; there is no accept in the same cycle as the output handshake.
- `out_ready` outside DONE is ignored.
- `rst` in any state (including mid-BUSY) → IDLE, and the in-flight operation is discarded.
- Reset values: `out_valid=0`, `product=0`, all internal registers 0. `in_ready=0` while `rst` is high and 1 in the first cycle after.

## Timing
- Accept at edge E. Steps occur at edges E+1..E+32, and DONE is entered at edge E+32. `out_valid` is high in the cycle after edge E+32.
- Latency is fixed at 32 cycles without early exit.
- Throughput: one operation per 34 cycles minimum (accept, 32 steps, 1 DONE cycle with `out_ready` high).
- `product` is a register output with no combinational path from the inputs. `in_ready` depends only on state and `rst`.

## Configuration
- `MUL_SEQ_EARLY_EXIT_EN` defined:
  - In BUSY, if `mplier==0` at the start of a cycle, no step is performed and the block goes → DONE at that edge.
  - Latency = 1 for b=0. Otherwise latency = min(m+2, 32), where m is the index of the highest set bit of b.
  - The product is identical to the non-early-exit result.
- Not defined: every operation takes exactly 32 steps; the `mplier==0` check is absent.

## Structure
- Shared package `mul_pkg`:
  - State enum {IDLE, BUSY, DONE}.
  - `MUL_N=32`.
  - `MUL_STEPS=32`.
- One sub-module, `add_co`: N-bit ripple adder with carry-in and carry-out.
  - Two instances are chained low→high for the 2N-bit accumulate.
  - The low instance has carry-in 0; the high instance takes the low instance's carry-out.
- The FSM and shift registers stay in `mul_seq`.

## Test plan
- a=3, b=5, `out_ready=1`, macro off → `product=0x0000_0000_0000_000F`; `out_valid` rises exactly 32 cycles after accept; `in_ready` high again 1 cycle later.
- a=b=0xFFFF_FFFF → `product=0xFFFF_FFFE_0000_0001`. Also a=0x8000_0000, b=2 → `0x0000_0001_0000_0000` (carry across adder halves).
- Backpressure: `out_ready=0` for 10 cycles in DONE → `product` and `out_valid` stable, `in_ready=0`, new `in_valid` ignored. Raising `out_ready` → IDLE next cycle.
- `rst` pulsed 1 cycle at step 10 of a=7, b=6 → next cycle IDLE, `out_valid=0`, `product=0`. Re-issuing a=7, b=6 → `product=42`.
- `in_valid` toggled with a=9, b=9 during BUSY of a=2, b=3 → result 6; the second operand pair is never accepted.
- Macro on:
  - b=0 → latency 1, product 0.
  - b=1, a=5 → latency 2, product 5.
  - a=0x1234_5678, b=0x10 → latency 6, product 0x1_2345_6780.
  - b=0x8000_0000 → latency 32.
